// File: rtl/xbar_pkg.sv
// Shared types and helpers for the registered, arbitrated router crossbar.
package xbar_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } port_state_t;

  // Index width for a count of ports; never narrower than one bit.
  function automatic int dest_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. The pointer itself is owned by the caller.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = dest_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] sel_s;

  function automatic int rot_idx(input logic [IDX_W-1:0] base, input int offset);
    int sum_v;
    sum_v = int'(base) + offset;
    return (sum_v >= N) ? sum_v - N : sum_v;
  endfunction

  // Scan from the farthest offset back to ptr so the nearest requester is written last.
  always_comb begin
    sel_s = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sel_s = req[rot_idx(ptr, k)] ? IDX_W'(rot_idx(ptr, k)) : sel_s;
    end
  end

  // One-hot and binary views of the selected requester.
  always_comb begin
    any        = |req;
    gnt_idx    = sel_s;
    gnt        = '0;
    gnt[sel_s] = any;
  end

endmodule

// File: rtl/xbar_alloc.sv
// Crossbar allocator: per output a round-robin arbiter, a wormhole lock that holds
// the granted input until its tail flit, and a single-entry valid/ready register.
module xbar_alloc
  import xbar_pkg::*;
#(
  parameter int INPUTS    = 7,
  parameter int OUTPUTS   = 7,
  parameter int FLIT_SIZE = 32,
  parameter int DEST_W    = dest_width(OUTPUTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUTS-1:0]                  in_valid,
  input  logic [INPUTS-1:0][FLIT_SIZE-1:0]   in_data,
  input  logic [INPUTS-1:0][DEST_W-1:0]      in_dest,
  input  logic [INPUTS-1:0]                  in_tail,
  output logic [INPUTS-1:0]                  in_ready,
  output logic [OUTPUTS-1:0]                 out_valid,
  output logic [OUTPUTS-1:0][FLIT_SIZE-1:0]  out_data,
  output logic [OUTPUTS-1:0]                 out_tail,
  input  logic [OUTPUTS-1:0]                 out_ready,
  output logic [INPUTS-1:0]                  drop
);

  localparam int              IN_W     = dest_width(INPUTS);
  localparam logic [DEST_W:0] DEST_LIM = (DEST_W + 1)'(OUTPUTS);

  logic [INPUTS-1:0] legal_s;
  logic [INPUTS-1:0] gnt_s [OUTPUTS];
  logic [INPUTS-1:0] drop_r;

  function automatic logic [IN_W-1:0] next_idx(input logic [IN_W-1:0] idx);
    return (idx == IN_W'(INPUTS - 1)) ? '0 : idx + 1'b1;
  endfunction

  // An input's destination is legal only when it names an existing output.
  always_comb begin
    legal_s = '0;
    for (int i = 0; i < INPUTS; i++) begin
      legal_s[i] = ({1'b0, in_dest[i]} < DEST_LIM);
    end
  end

  for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
    port_state_t          state_r;
    logic [IN_W-1:0]      owner_r;
    logic [IN_W-1:0]      ptr_r;
    logic [INPUTS-1:0]    req_s;
    logic [INPUTS-1:0]    arb_gnt_s;
    logic [IN_W-1:0]      arb_idx_s;
    logic                 arb_any_s;
    logic [INPUTS-1:0]    port_gnt_s;
    logic [IN_W-1:0]      win_idx_s;
    logic                 win_s;
    logic                 slot_free_s;
    logic                 valid_r;
    logic                 tail_r;
    logic [FLIT_SIZE-1:0] data_r;

    // Requesters are valid inputs naming this output.
    always_comb begin
      req_s = '0;
      for (int i = 0; i < INPUTS; i++) begin
        req_s[i] = in_valid[i] & (in_dest[i] == DEST_W'(o));
      end
    end

    assign slot_free_s = !valid_r | out_ready[o];

    rr_arbiter #(
      .N     (INPUTS),
      .IDX_W (IN_W)
    ) u_arb (
      .req     (req_s),
      .ptr     (ptr_r),
      .gnt     (arb_gnt_s),
      .gnt_idx (arb_idx_s),
      .any     (arb_any_s)
    );

    // While locked only the owner can win; otherwise the arbiter decides.
    always_comb begin
      port_gnt_s = '0;
      win_s      = 1'b0;
      win_idx_s  = owner_r;
      case (state_r)
        IDLE: begin
          win_s      = slot_free_s & arb_any_s;
          win_idx_s  = arb_idx_s;
          port_gnt_s = slot_free_s ? arb_gnt_s : '0;
        end
        LOCKED: begin
          win_s               = slot_free_s & req_s[owner_r];
          win_idx_s           = owner_r;
          port_gnt_s[owner_r] = win_s;
        end
        default: begin
          win_s = 1'b0;
        end
      endcase
    end

    // Wormhole lock, round-robin pointer and the output flit register.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= IDLE;
        owner_r <= '0;
        ptr_r   <= '0;
        valid_r <= 1'b0;
        tail_r  <= 1'b0;
        data_r  <= '0;
      end else begin
        if (win_s) begin
          valid_r <= 1'b1;
          data_r  <= in_data[win_idx_s];
          tail_r  <= in_tail[win_idx_s];
        end else if (out_ready[o]) begin
          valid_r <= 1'b0;
        end
        case (state_r)
          IDLE: begin
            if (win_s && in_tail[win_idx_s]) begin
              ptr_r <= next_idx(win_idx_s);
            end else if (win_s) begin
              state_r <= LOCKED;
              owner_r <= win_idx_s;
            end
          end
          LOCKED: begin
            if (win_s && in_tail[owner_r]) begin
              state_r <= IDLE;
              ptr_r   <= next_idx(owner_r);
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end

    assign gnt_s[o]     = port_gnt_s;
    assign out_valid[o] = valid_r;
    assign out_data[o]  = data_r;
    assign out_tail[o]  = tail_r;
  end

  // Accept granted flits and swallow illegal ones; nothing is accepted in reset.
  always_comb begin
    in_ready = '0;
    if (rst) begin
      in_ready = '0;
    end else begin
      for (int p = 0; p < OUTPUTS; p++) begin
        in_ready = in_ready | gnt_s[p];
      end
      in_ready = in_ready | (in_valid & ~legal_s);
    end
  end

  // Discard notification follows the accepting cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= '0;
    end else begin
      drop_r <= in_valid & ~legal_s;
    end
  end

  assign drop = drop_r;

endmodule

// File: tb/tb_xbar_alloc.sv
// Self-checking bench for xbar_alloc: directed scenarios plus randomized traffic
// checked against a behavioural crossbar model.
module tb_xbar_alloc;

  localparam int NI = 7;
  localparam int NO = 7;
  localparam int FW = 32;
  localparam int DW = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NI-1:0]           in_valid;
  logic [NI-1:0][FW-1:0]   in_data;
  logic [NI-1:0][DW-1:0]   in_dest;
  logic [NI-1:0]           in_tail;
  logic [NI-1:0]           in_ready;
  logic [NO-1:0]           out_valid;
  logic [NO-1:0][FW-1:0]   out_data;
  logic [NO-1:0]           out_tail;
  logic [NO-1:0]           out_ready;
  logic [NI-1:0]           drop;

  always #5 clk = ~clk;

  xbar_alloc #(
    .INPUTS    (NI),
    .OUTPUTS   (NO),
    .FLIT_SIZE (FW),
    .DEST_W    (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .in_tail   (in_tail),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_tail  (out_tail),
    .out_ready (out_ready),
    .drop      (drop)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, one entry per output port.
  bit            m_locked [NO];
  int            m_owner  [NO];
  int            m_ptr    [NO];
  bit            m_ov     [NO];
  logic [FW-1:0] m_od     [NO];
  bit            m_ot     [NO];
  int            m_gi     [NO];
  logic [NI-1:0] exp_ready;
  logic [NI-1:0] m_drop;

  task automatic model_ready();
    exp_ready = '0;
    for (int o = 0; o < NO; o++) begin
      bit free;
      m_gi[o] = -1;
      free = !m_ov[o] || out_ready[o];
      if (!rst && free) begin
        if (m_locked[o]) begin
          if (in_valid[m_owner[o]] && int'(in_dest[m_owner[o]]) == o) m_gi[o] = m_owner[o];
        end else begin
          for (int k = 0; k < NI; k++) begin
            int i;
            i = (m_ptr[o] + k) % NI;
            if (m_gi[o] < 0 && in_valid[i] && int'(in_dest[i]) == o) m_gi[o] = i;
          end
        end
      end
      if (m_gi[o] >= 0) exp_ready[m_gi[o]] = 1'b1;
    end
    for (int i = 0; i < NI; i++) begin
      if (!rst && in_valid[i] && int'(in_dest[i]) >= NO) exp_ready[i] = 1'b1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_drop = '0;
      for (int o = 0; o < NO; o++) begin
        m_locked[o] = 1'b0; m_owner[o] = 0; m_ptr[o] = 0;
        m_ov[o] = 1'b0; m_od[o] = '0; m_ot[o] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) m_drop[i] = in_valid[i] && int'(in_dest[i]) >= NO;
      for (int o = 0; o < NO; o++) begin
        if (m_gi[o] >= 0) begin
          m_ov[o] = 1'b1;
          m_od[o] = in_data[m_gi[o]];
          m_ot[o] = in_tail[m_gi[o]];
          if (!m_locked[o]) begin
            if (in_tail[m_gi[o]]) m_ptr[o] = (m_gi[o] + 1) % NI;
            else begin m_locked[o] = 1'b1; m_owner[o] = m_gi[o]; end
          end else if (in_tail[m_gi[o]]) begin
            m_locked[o] = 1'b0;
            m_ptr[o] = (m_owner[o] + 1) % NI;
          end
        end else if (out_ready[o]) begin
          m_ov[o] = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_tail = '0; in_data = '0; in_dest = '0;
  endtask

  task automatic tick();
    model_ready();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); out_ready = '1;
    in_valid = '1;
    tick(); tick();
    vectors++;
    if (in_ready !== 7'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want %b", in_ready, 7'b0); end
    vectors++;
    if (out_valid !== 7'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++;
    if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    vectors++;
    if (out_tail !== 7'b0 || drop !== 7'b0) begin miscompares++; $display("FAIL reset_tail_drop: got %b/%b want 0/0", out_tail, drop); end
    rst = 1'b0; idle_inputs();
  endtask

  task automatic test_single_flit();
    idle_inputs(); out_ready = '1;
    in_valid[2] = 1'b1; in_dest[2] = 3'd4; in_data[2] = 32'hA5A5_0001; in_tail[2] = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 7'b0000100) begin miscompares++; $display("FAIL single_in_ready: got %b want %b", in_ready, 7'b0000100); end
    tick(); idle_inputs();
    vectors++;
    if (out_valid[4] !== 1'b1 || out_data[4] !== 32'hA5A5_0001 || out_tail[4] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_out: got v%b d%h t%b want v1 da5a50001 t1", out_valid[4], out_data[4], out_tail[4]);
    end
    vectors++;
    if (out_valid !== 7'b0010000) begin miscompares++; $display("FAIL single_only_out4: got %b want %b", out_valid, 7'b0010000); end
  endtask

  task automatic test_round_robin();
    int order [3] = '{0, 3, 5};
    logic [NI-1:0] want;
    idle_inputs(); out_ready = '1;
    for (int c = 0; c < 9; c++) begin
      foreach (order[j]) begin
        in_valid[order[j]] = 1'b1; in_dest[order[j]] = 3'd1;
        in_tail[order[j]] = 1'b1; in_data[order[j]] = $urandom();
      end
      want = 7'b1 << order[c % 3];
      #1;
      vectors++;
      if (in_ready !== want) begin miscompares++; $display("FAIL rr_grant cyc %0d: got %b want %b", c, in_ready, want); end
      tick();
      vectors++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== m_od[1]) begin
        miscompares++;
        $display("FAIL rr_out cyc %0d: got v%b d%h want v1 d%h", c, out_valid[1], out_data[1], m_od[1]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wormhole();
    logic [NI-1:0] want;
    logic [FW-1:0] want_d;
    out_ready = '1;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (c < 4) begin
        in_valid[1] = 1'b1; in_dest[1] = 3'd0; in_tail[1] = (c == 3); in_data[1] = 32'h1000_0000 + c;
      end
      in_valid[6] = 1'b1; in_dest[6] = 3'd0; in_tail[6] = 1'b1; in_data[6] = 32'h6666_0000 + c;
      want   = (c < 4) ? 7'b0000010 : 7'b1000000;
      want_d = (c < 4) ? 32'h1000_0000 + c : 32'h6666_0000 + c;
      #1;
      vectors++;
      if (in_ready !== want) begin miscompares++; $display("FAIL worm_grant cyc %0d: got %b want %b", c, in_ready, want); end
      tick();
      vectors++;
      if (out_valid[0] !== 1'b1 || out_data[0] !== want_d) begin
        miscompares++;
        $display("FAIL worm_out cyc %0d: got v%b d%h want v1 d%h", c, out_valid[0], out_data[0], want_d);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs(); out_ready = '1; out_ready[3] = 1'b0;
    in_valid[4] = 1'b1; in_dest[4] = 3'd3; in_tail[4] = 1'b1; in_data[4] = 32'hBEEF_0004;
    tick();
    idle_inputs();
    in_valid[5] = 1'b1; in_dest[5] = 3'd3; in_tail[5] = 1'b1; in_data[5] = 32'hBEEF_0005;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (in_ready[5] !== 1'b0) begin miscompares++; $display("FAIL bp_stall_ready cyc %0d: got %b want 0", c, in_ready[5]); end
      tick();
      vectors++;
      if (out_valid[3] !== 1'b1 || out_data[3] !== 32'hBEEF_0004) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d: got v%b d%h want v1 dbeef0004", c, out_valid[3], out_data[3]);
      end
    end
    out_ready[3] = 1'b1;
    #1;
    vectors++;
    if (in_ready[5] !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", in_ready[5]); end
    tick();
    vectors++;
    if (out_valid[3] !== 1'b1 || out_data[3] !== 32'hBEEF_0005) begin
      miscompares++;
      $display("FAIL bp_reload: got v%b d%h want v1 dbeef0005", out_valid[3], out_data[3]);
    end
    idle_inputs();
  endtask

  task automatic test_illegal_dest();
    idle_inputs(); out_ready = '1;
    tick();
    in_valid[0] = 1'b1; in_dest[0] = 3'd7; in_tail[0] = 1'b1; in_data[0] = 32'hDEAD_0000;
    #1;
    vectors++;
    if (in_ready !== 7'b0000001) begin miscompares++; $display("FAIL illegal_ready: got %b want %b", in_ready, 7'b0000001); end
    tick(); idle_inputs();
    vectors++;
    if (drop !== 7'b0000001) begin miscompares++; $display("FAIL illegal_drop: got %b want %b", drop, 7'b0000001); end
    vectors++;
    if (out_valid !== 7'b0) begin miscompares++; $display("FAIL illegal_no_out: got %b want 0", out_valid); end
    tick();
    vectors++;
    if (drop !== 7'b0) begin miscompares++; $display("FAIL illegal_drop_once: got %b want 0", drop); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = '1;
    for (int c = 0; c < 2; c++) begin
      idle_inputs();
      in_valid[2] = 1'b1; in_dest[2] = 3'd5; in_tail[2] = 1'b0; in_data[2] = 32'h2222_0000 + c;
      in_valid[3] = 1'b1; in_dest[3] = 3'd5; in_tail[3] = 1'b1; in_data[3] = 32'h3333_0000;
      #1;
      vectors++;
      if (in_ready !== 7'b0000100) begin miscompares++; $display("FAIL rstpkt_lock cyc %0d: got %b want %b", c, in_ready, 7'b0000100); end
      tick();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 7'b0) begin miscompares++; $display("FAIL rstpkt_ready_in_reset: got %b want 0", in_ready); end
    tick();
    rst = 1'b0;
    vectors++;
    if (out_valid !== 7'b0) begin miscompares++; $display("FAIL rstpkt_out_cleared: got %b want 0", out_valid); end
    in_valid[2] = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 7'b0001000) begin miscompares++; $display("FAIL rstpkt_new_owner: got %b want %b", in_ready, 7'b0001000); end
    tick();
    vectors++;
    if (out_valid[5] !== 1'b1 || out_data[5] !== 32'h3333_0000) begin
      miscompares++;
      $display("FAIL rstpkt_new_flit: got v%b d%h want v1 d33330000", out_valid[5], out_data[5]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NI; i++) begin
        in_valid[i] = ($urandom_range(0, 2) != 0);
        in_dest[i]  = DW'($urandom_range(0, 7));
        in_tail[i]  = ($urandom_range(0, 2) == 0);
        in_data[i]  = $urandom();
      end
      for (int o = 0; o < NO; o++) out_ready[o] = ($urandom_range(0, 3) != 0);
      #1;
      model_ready();
      vectors++;
      if (in_ready !== exp_ready) begin miscompares++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, in_ready, exp_ready); end
      tick();
      vectors++;
      if (drop !== m_drop) begin miscompares++; $display("FAIL rand_drop cyc %0d: got %b want %b", c, drop, m_drop); end
      for (int o = 0; o < NO; o++) begin
        vectors++;
        if (out_valid[o] !== m_ov[o] || out_data[o] !== m_od[o] || out_tail[o] !== m_ot[o]) begin
          miscompares++;
          $display("FAIL rand_out[%0d] cyc %0d: got v%b d%h t%b want v%b d%h t%b",
                   o, c, out_valid[o], out_data[o], out_tail[o], m_ov[o], m_od[o], m_ot[o]);
        end
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    out_ready = '1;
    test_reset();
    test_single_flit();
    test_round_robin();
    test_wormhole();
    test_backpressure();
    test_illegal_dest();
    test_reset_mid_packet();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
